sh7604_ext_bus_slave: RTL



---
 rtl/sh7604_pkg.sv | 27 ++
 rtl/sh7604_ext_bus_waitcnt.sv | 30 +++
 rtl/sh7604_ext_bus_slave.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/sh7604_pkg.sv
// Shared types and constants for the SH7604 external-bus slave.
// Optional feature macro used by the top level: EXTBUS_TIMEOUT_EN.
package sh7604_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WDATA,
    REQ,
    HOLD,
    ENDC
  } ExtBusState_t;

  typedef bit [3:0] WaitCnt_t;

  localparam int          DATA_W         = 32;
  localparam logic [3:0]  EXTBUS_RD_BE   = 4'hF;
  localparam logic [31:0] EXTBUS_TO_DATA = 32'hFFFF_FFFF;

  // Area number of the lowest-numbered asserted chip select (CS_N active low).
  function automatic logic [1:0] cs_encode(input logic [3:0] cs_n);
    if (!cs_n[0]) return 2'd0;
    if (!cs_n[1]) return 2'd1;
    if (!cs_n[2]) return 2'd2;
    return 2'd3;
  endfunction

endpackage

// File: rtl/sh7604_ext_bus_waitcnt.sv
// Minimum-wait-state counter: loads on bus-cycle capture, then counts down
// once per CE_R tick and saturates at zero.
module sh7604_ext_bus_waitcnt
  import sh7604_pkg::*;
(
  input  logic     CLK,
  input  logic     RST_N,
  input  logic     CE_R,
  input  logic     load,
  input  WaitCnt_t load_val,
  output logic     zero
);

  WaitCnt_t cnt;

  // Load has priority; otherwise decrement toward zero on every tick.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cnt <= '0;
    end else if (CE_R) begin
      if (load)
        cnt <= load_val;
      else if (cnt != '0)
        cnt <= cnt - 4'd1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/sh7604_ext_bus_slave.sv
// SH7604 external-bus responder: decodes the CPU bus cycle, holds WAIT_N low
// while a request/acknowledge backend services it, and returns read data.
// Optional feature: define EXTBUS_TIMEOUT_EN to abort requests that see no
// MEM_ACK within TIMEOUT REQ ticks (ERR pulse, read data forced to all ones).
module sh7604_ext_bus_slave
  import sh7604_pkg::*;
#(
  parameter logic [3:0] WAIT0   = 4'd1,
  parameter logic [3:0] WAIT1   = 4'd1,
  parameter logic [3:0] WAIT2   = 4'd2,
  parameter logic [3:0] WAIT3   = 4'd2,
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              CE_R,
  input  logic [26:0]       A,
  input  logic [DATA_W-1:0] DO,
  input  logic              BS_N,
  input  logic [3:0]        CS_N,
  input  logic              RD_N,
  input  logic [3:0]        WE_N,
  output logic [DATA_W-1:0] DI,
  output logic              WAIT_N,
  output logic [26:0]       MEM_A,
  output logic [DATA_W-1:0] MEM_DO,
  output logic [3:0]        MEM_BE,
  output logic [1:0]        MEM_CS,
  output logic              MEM_WR,
  output logic              MEM_REQ,
  input  logic              MEM_ACK,
  input  logic [DATA_W-1:0] MEM_DI,
  output logic              ERR
);

  ExtBusState_t      state_q, state_d;
  logic              bus_start;
  logic              ack_hit;
  logic              ack_pend_q;
  logic              capture, wr_load, req_done, to_fire, hold_done;
  logic              req_enter;
  logic              to_expire;
  logic              wait_zero;
  logic [1:0]        area;
  WaitCnt_t          wait_val;
  logic [DATA_W-1:0] rd_hold;

  assign bus_start = !BS_N && (CS_N != 4'hF);
  assign area      = cs_encode(CS_N);
  // The backend acks on any CLK; an ack between CE_R ticks is parked until the next tick.
  assign ack_hit   = MEM_ACK && MEM_REQ && (state_q == REQ);
  assign req_enter = (capture && !RD_N) || wr_load;

  // Minimum wait states for the decoded area.
  always_comb begin
    wait_val = WaitCnt_t'(WAIT0);
    case (area)
      2'd1:    wait_val = WaitCnt_t'(WAIT1);
      2'd2:    wait_val = WaitCnt_t'(WAIT2);
      2'd3:    wait_val = WaitCnt_t'(WAIT3);
      default: wait_val = WaitCnt_t'(WAIT0);
    endcase
  end

  sh7604_ext_bus_waitcnt u_waitcnt (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .CE_R     (CE_R),
    .load     (capture),
    .load_val (wait_val),
    .zero     (wait_zero)
  );

  // Next-state decode and per-tick action strobes.
  always_comb begin
    state_d   = state_q;
    capture   = 1'b0;
    wr_load   = 1'b0;
    req_done  = 1'b0;
    to_fire   = 1'b0;
    hold_done = 1'b0;
    case (state_q)
      IDLE:  if (bus_start) capture = 1'b1;
      WDATA: if (WE_N != 4'hF) wr_load = 1'b1;
      REQ: begin
        if (ack_pend_q || ack_hit) req_done = 1'b1;
        else if (to_expire)        to_fire  = 1'b1;
      end
      HOLD:  if (wait_zero) hold_done = 1'b1;
      ENDC: begin
        if (bus_start)                    capture = 1'b1;
        else if (RD_N && (WE_N == 4'hF))  state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (capture)             state_d = RD_N ? WDATA : REQ;
    if (wr_load)             state_d = REQ;
    if (req_done || to_fire) state_d = HOLD;
    if (hold_done)           state_d = ENDC;
  end

  // State register, advancing only on CE_R ticks.
  always_ff @(posedge CLK) begin
    if (!RST_N)
      state_q <= IDLE;
    else if (CE_R)
      state_q <= state_d;
  end

  // Bus latches, request handshake, wait line and read-data return.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      DI         <= '0;
      WAIT_N     <= 1'b1;
      MEM_A      <= '0;
      MEM_DO     <= '0;
      MEM_BE     <= '0;
      MEM_CS     <= '0;
      MEM_WR     <= 1'b0;
      MEM_REQ    <= 1'b0;
      ack_pend_q <= 1'b0;
    end else if (CE_R) begin
      if (capture) begin
        MEM_A  <= A;
        MEM_CS <= area;
        WAIT_N <= 1'b0;
        if (!RD_N) begin
          MEM_WR  <= 1'b0;
          MEM_BE  <= EXTBUS_RD_BE;
          MEM_REQ <= 1'b1;
        end
      end
      if (wr_load) begin
        MEM_DO  <= DO;
        MEM_BE  <= ~WE_N;
        MEM_WR  <= 1'b1;
        MEM_REQ <= 1'b1;
      end
      if (req_done) begin
        MEM_REQ    <= 1'b0;
        ack_pend_q <= 1'b0;
        if (!MEM_WR) DI <= ack_pend_q ? rd_hold : MEM_DI;
      end
      if (to_fire) begin
        MEM_REQ <= 1'b0;
        if (!MEM_WR) DI <= EXTBUS_TO_DATA;
      end
      if (hold_done) WAIT_N <= 1'b1;
    end else if (ack_hit) begin
      MEM_REQ    <= 1'b0;
      ack_pend_q <= 1'b1;
    end
  end

  // Read data parked from an ack that landed between ticks.
  always_ff @(posedge CLK) begin
    if (ack_hit && !CE_R) rd_hold <= MEM_DI;
  end

`ifdef EXTBUS_TIMEOUT_EN
  logic [7:0] to_cnt_q;

  // REQ tick counter, restarted whenever a new request is issued.
  always_ff @(posedge CLK) begin
    if (!RST_N)
      to_cnt_q <= '0;
    else if (CE_R) begin
      if (req_enter)            to_cnt_q <= '0;
      else if (state_q == REQ)  to_cnt_q <= to_cnt_q + 8'd1;
    end
  end

  assign to_expire = (state_q == REQ) && (to_cnt_q == TIMEOUT - 8'd1);

  // One-tick abort pulse.
  always_ff @(posedge CLK) begin
    if (!RST_N)
      ERR <= 1'b0;
    else if (CE_R)
      ERR <= to_fire;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^{TIMEOUT, req_enter};
  assign to_expire      = 1'b0;
  assign ERR            = 1'b0;
`endif

endmodule
